// File: rtl/tap_ctrl_if.sv
// TAP controller signal bundle: TMS in, IR/DR strobes and TDO controls out.
// master = the TAP controller, slave = the consumer that drives TMS.
interface tap_ctrl_if;
    logic TMS;
    logic ir_capture, ir_shift, ir_update;
    logic dr_capture, dr_shift, dr_update;
    logic tlr_reset, test_reset;
    logic select_ir, tdo_en;

    modport master (
        input  TMS,
        output ir_capture, ir_shift, ir_update,
        output dr_capture, dr_shift, dr_update,
        output tlr_reset, test_reset, select_ir, tdo_en
    );

    modport slave (
        output TMS,
        input  ir_capture, ir_shift, ir_update,
        input  dr_capture, dr_shift, dr_update,
        input  tlr_reset, test_reset, select_ir, tdo_en
    );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM with Moore-decoded IR/DR strobes.
// Optional TAP_STATE_OUT_EN exposes the raw state register as tap_state.
module tap_ctrl (
    input  logic TCK,
    input  logic TRST,
    tap_ctrl_if.master tap
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0] tap_state
`endif
);
    localparam logic [3:0] TLR    = 4'hF;
    localparam logic [3:0] RTI    = 4'hC;
    localparam logic [3:0] SEL_DR = 4'h7;
    localparam logic [3:0] CAP_DR = 4'h6;
    localparam logic [3:0] SH_DR  = 4'h2;
    localparam logic [3:0] EX1_DR = 4'h1;
    localparam logic [3:0] PA_DR  = 4'h3;
    localparam logic [3:0] EX2_DR = 4'h0;
    localparam logic [3:0] UPD_DR = 4'h5;
    localparam logic [3:0] SEL_IR = 4'h4;
    localparam logic [3:0] CAP_IR = 4'hE;
    localparam logic [3:0] SH_IR  = 4'hA;
    localparam logic [3:0] EX1_IR = 4'h9;
    localparam logic [3:0] PA_IR  = 4'hB;
    localparam logic [3:0] EX2_IR = 4'h8;
    localparam logic [3:0] UPD_IR = 4'hD;

    logic [3:0] state, state_nxt;
    logic       test_reset_q;

    always_comb begin
        state_nxt = state;
        case (state)
            TLR:    state_nxt = tap.TMS ? TLR    : RTI;
            RTI:    state_nxt = tap.TMS ? SEL_DR : RTI;
            SEL_DR: state_nxt = tap.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_nxt = tap.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_nxt = tap.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_nxt = tap.TMS ? UPD_DR : PA_DR;
            PA_DR:  state_nxt = tap.TMS ? EX2_DR : PA_DR;
            EX2_DR: state_nxt = tap.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_nxt = tap.TMS ? SEL_DR : RTI;
            SEL_IR: state_nxt = tap.TMS ? TLR    : CAP_IR;
            CAP_IR: state_nxt = tap.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_nxt = tap.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_nxt = tap.TMS ? UPD_IR : PA_IR;
            PA_IR:  state_nxt = tap.TMS ? EX2_IR : PA_IR;
            EX2_IR: state_nxt = tap.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_nxt = tap.TMS ? SEL_DR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // test_reset marks TLR entry only; staying in TLR does not re-pulse it.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state        <= TLR;
            test_reset_q <= 1'b1;
        end else begin
            state        <= state_nxt;
            test_reset_q <= (state_nxt == TLR) && (state != TLR);
        end
    end

    assign tap.ir_capture = (state == CAP_IR);
    assign tap.ir_shift   = (state == SH_IR);
    assign tap.ir_update  = (state == UPD_IR);
    assign tap.dr_capture = (state == CAP_DR);
    assign tap.dr_shift   = (state == SH_DR);
    assign tap.dr_update  = (state == UPD_DR);
    assign tap.tlr_reset  = (state == TLR);
    assign tap.test_reset = test_reset_q;
    assign tap.tdo_en     = (state == SH_IR) || (state == SH_DR);

    // IR column excludes SEL_IR, which still belongs to the DR/other mux leg.
    assign tap.select_ir  = (state == CAP_IR) || (state == SH_IR) || (state == EX1_IR) ||
                            (state == PA_IR)  || (state == EX2_IR) || (state == UPD_IR);

`ifdef TAP_STATE_OUT_EN
    assign tap_state = state;
`endif
endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: abstract (phase, column) reference model feeds
// an expectation queue that a negedge monitor drains against DUT outputs.
module tb_tap_ctrl;
    logic TCK = 1'b0;
    logic TRST = 1'b0;
    tap_ctrl_if tif();

`ifdef TAP_STATE_OUT_EN
    logic [3:0] tap_state;
    tap_ctrl dut (.TCK(TCK), .TRST(TRST), .tap(tif), .tap_state(tap_state));
`else
    tap_ctrl dut (.TCK(TCK), .TRST(TRST), .tap(tif));
`endif

    always #5 TCK = ~TCK;

    typedef enum int {P_TLR, P_RTI, P_SEL, P_CAP, P_SH, P_EX1, P_PA, P_EX2, P_UPD} phase_t;
    typedef struct packed {
        logic [9:0] o;
        logic [3:0] st;
    } exp_t;

    exp_t   q[$];
    phase_t m_ph = P_TLR;
    bit     m_ir = 1'b0;
    bit     m_tr = 1'b0;
    int     checks = 0;
    int     errors = 0;
    bit     done = 1'b0;

    // 1149.1 state code for an abstract (phase, column) pair
    function automatic logic [3:0] enc(input phase_t ph, input bit ir);
        case (ph)
            P_TLR: return 4'hF;
            P_RTI: return 4'hC;
            P_SEL: return ir ? 4'h4 : 4'h7;
            P_CAP: return ir ? 4'hE : 4'h6;
            P_SH:  return ir ? 4'hA : 4'h2;
            P_EX1: return ir ? 4'h9 : 4'h1;
            P_PA:  return ir ? 4'hB : 4'h3;
            P_EX2: return ir ? 4'h8 : 4'h0;
            default: return ir ? 4'hD : 4'h5;
        endcase
    endfunction

    task automatic model_edge(input bit tms, input bit trst);
        phase_t nx;
        bit     nir;
        nir = m_ir;
        if (trst) begin
            nx = P_TLR; nir = 1'b0; m_tr = 1'b1;
        end else begin
            case (m_ph)
                P_TLR: nx = tms ? P_TLR : P_RTI;
                P_RTI: begin nx = tms ? P_SEL : P_RTI; nir = 1'b0; end
                P_SEL: begin
                    if (!m_ir) begin nx = tms ? P_SEL : P_CAP; nir = tms; end
                    else       begin nx = tms ? P_TLR : P_CAP; end
                end
                P_CAP, P_SH: nx = tms ? P_EX1 : P_SH;
                P_EX1: nx = tms ? P_UPD : P_PA;
                P_PA:  nx = tms ? P_EX2 : P_PA;
                P_EX2: nx = tms ? P_UPD : P_SH;
                default: begin nx = tms ? P_SEL : P_RTI; nir = 1'b0; end
            endcase
            if (nx == P_TLR || nx == P_RTI) nir = 1'b0;
            m_tr = (nx == P_TLR) && (m_ph != P_TLR);
        end
        m_ph = nx;
        m_ir = nir;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit cap, sh, upd;
        cap = (m_ph == P_CAP); sh = (m_ph == P_SH); upd = (m_ph == P_UPD);
        e.o = {cap & m_ir, sh & m_ir, upd & m_ir, cap & ~m_ir, sh & ~m_ir, upd & ~m_ir,
               m_ph == P_TLR, m_tr, m_ir && (m_ph >= P_CAP), sh};
        e.st = enc(m_ph, m_ir);
        return e;
    endfunction

    task automatic step(input bit tms, input bit trst);
        tif.TMS = tms;
        TRST    = trst;
        @(posedge TCK);
        #1;
        model_edge(tms, trst);
        q.push_back(model_out());
    endtask

    task automatic run_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i] == "1", 1'b0);
    endtask

    // Monitor: every negedge with a pending expectation compares the DUT outputs.
    initial begin
        exp_t       e;
        logic [9:0] act;
        logic [5:0] strobes;
        while (!done) begin
            @(negedge TCK);
            if (q.size() > 0) begin
                e = q.pop_front();
                act = {tif.ir_capture, tif.ir_shift, tif.ir_update,
                       tif.dr_capture, tif.dr_shift, tif.dr_update,
                       tif.tlr_reset, tif.test_reset, tif.select_ir, tif.tdo_en};
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL outputs t=%0t got %b want %b", $time, act, e.o);
                end
                strobes = act[9:4];
                checks++;
                if ($countones(strobes) > 1) begin
                    errors++;
                    $display("FAIL onehot t=%0t got %b want at most one strobe", $time, strobes);
                end
`ifdef TAP_STATE_OUT_EN
                checks++;
                if (tap_state !== e.st) begin
                    errors++;
                    $display("FAIL tap_state t=%0t got %h want %h", $time, tap_state, e.st);
                end
`endif
            end
        end
    end

    string paths[16] = '{"", "0", "01", "010", "0100", "0101", "01010", "010101",
                         "01011", "011", "0110", "01100", "01101", "011010",
                         "0110101", "011011"};

    initial begin
        tif.TMS = 1'b0;
        // reset then leave TLR
        step(0, 1); step(0, 1); step(0, 0);
        // IR scan: capture, 4 shifts, exit, update, RTI
        run_str("1100000110");
        // DR scan with a pause in the middle
        run_str("100000000010010110");
        // every state, then five TMS=1 edges to TLR and a few more to confirm no re-pulse
        for (int p = 0; p < 16; p++) begin
            step(0, 1);
            run_str(paths[p]);
            run_str("1111111");
        end
        // TRST while shifting DR, then idle in TLR and leave
        step(0, 1); run_str("0100"); step(0, 1); run_str("1100");
        // random TMS with occasional TRST
        for (int i = 0; i < 10000; i++)
            step($urandom_range(1, 0), $urandom_range(63, 0) == 0);
        repeat (3) @(posedge TCK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        done = 1'b1;
        @(negedge TCK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
